// File: rtl/opacc_pkg.sv
// opacc_pkg: shared enums and the accumulate helper for opacc_stream.
// Define OPACC_SAT_EN to make MAC accumulation saturate instead of wrap.
package opacc_pkg;
  typedef enum logic [1:0] {OP_LOAD, OP_MAC, OP_CLEAR, OP_RSVD} op_t;
  typedef enum logic {ST_IDLE, ST_DRAIN} state_t;
`ifdef OPACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam int MAXW = 64;
  // w-bit add (w <= MAXW) of an accumulator and an already-extended product
  function automatic logic [MAXW-1:0] acc_add(input logic [MAXW-1:0] acc, input logic [MAXW-1:0] prod,
                                               input int w, input bit sgn);
    logic [MAXW:0] sum;
    logic [MAXW-1:0] msk;
    logic [MAXW-1:0] res;
    logic ovf;
    msk = (w >= MAXW) ? '1 : ((MAXW'(1) << w) - MAXW'(1));
    sum = {1'b0, acc & msk} + {1'b0, prod & msk};
    res = sum[MAXW-1:0] & msk;
    ovf = sgn ? (acc[6'(w-1)] == prod[6'(w-1)]) && (res[6'(w-1)] != acc[6'(w-1)]) : sum[7'(w)];
    if (SAT_EN && ovf) res = !sgn ? msk : acc[6'(w-1)] ? (msk ^ (msk >> 1)) : (msk >> 1);
    return res;
  endfunction
endpackage

// File: rtl/opacc_mac_row.sv
// opacc_mac_row: one tile row of VL multiply-accumulate cells, acc[j] + a * b[j].
module opacc_mac_row import opacc_pkg::*; #(
  parameter int XLEN   = 8,
  parameter int ACCLEN = 32,
  parameter int VL     = 4,
  parameter int SIGNED = 1
) (
  input  logic [XLEN-1:0]      a,
  input  logic [VL*XLEN-1:0]   b,
  input  logic [VL*ACCLEN-1:0] acc,
  output logic [VL*ACCLEN-1:0] sum
);
  for (genvar j = 0; j < VL; j++) begin : g_cell
    logic [2*XLEN-1:0] ae, be, p;
    logic [ACCLEN-1:0] s;
    always_comb begin
      ae = {{XLEN{SIGNED != 0 && a[XLEN-1]}}, a};
      be = {{XLEN{SIGNED != 0 && b[j*XLEN+XLEN-1]}}, b[j*XLEN +: XLEN]};
      p  = ae * be;
      s  = ACCLEN'(acc_add(MAXW'(acc[j*ACCLEN +: ACCLEN]),
                           {{(MAXW-2*XLEN){SIGNED != 0 && p[2*XLEN-1]}}, p}, ACCLEN, SIGNED != 0));
    end
    assign sum[j*ACCLEN +: ACCLEN] = s;
  end
endmodule

// File: rtl/opacc_stream.sv
// opacc_stream: ML x VL outer-product accumulator tile with a LOAD/MAC/CLEAR command port
// and a row drain stream. Define OPACC_SAT_EN for saturating MAC accumulation.
module opacc_stream import opacc_pkg::*; #(
  parameter int XLEN   = 8,
  parameter int ACCLEN = 32,
  parameter int VL     = 4,
  parameter int ML     = 4,
  parameter int SIGNED = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [ML*XLEN-1:0]   vi_a,
  input  logic [VL*XLEN-1:0]   vi_b,
  input  logic [VL*ACCLEN-1:0] vi_c,
  input  logic                 drain_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VL*ACCLEN-1:0] vo_c,
  output logic                 out_last,
  output logic                 busy
);
  localparam int CW = ML > 1 ? $clog2(ML) : 1;
  localparam int RW = VL * ACCLEN;
  state_t state;
  op_t op;
  logic [CW-1:0] cnt;
  logic [RW-1:0] reg_c [ML];
  logic [RW-1:0] mac_c [ML];
  logic [RW-1:0] shin;
  logic fire, do_shift;
  assign op       = op_t'(in_op);
  assign in_ready = state == ST_IDLE && !drain_req;
  assign fire     = in_valid && in_ready;
  // LOAD and drain share one shift path; the drain feeds zeros so the tile empties
  assign do_shift = (fire && op == OP_LOAD) || (state == ST_DRAIN && out_ready);
  assign shin     = state == ST_DRAIN ? '0 : vi_c;
  assign vo_c     = out_valid ? reg_c[ML-1] : '0;
  for (genvar i = 0; i < ML; i++) begin : g_row
    opacc_mac_row #(.XLEN(XLEN), .ACCLEN(ACCLEN), .VL(VL), .SIGNED(SIGNED)) u_row (
      .a(vi_a[i*XLEN +: XLEN]), .b(vi_b), .acc(reg_c[i]), .sum(mac_c[i]));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < ML; i++) reg_c[i] <= '0;
    end else begin
      if (do_shift) begin
        reg_c[0] <= shin;
        for (int i = 1; i < ML; i++) reg_c[i] <= reg_c[i-1];
      end else if (fire && op == OP_MAC) reg_c <= mac_c;
      else if (fire && op == OP_CLEAR) for (int i = 0; i < ML; i++) reg_c[i] <= '0;
      if (state == ST_IDLE && drain_req) begin
        state     <= ST_DRAIN;
        out_valid <= 1'b1;
        busy      <= 1'b1;
        out_last  <= ML == 1;
      end else if (state == ST_DRAIN && out_ready) begin
        if (out_last) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_last  <= 1'b0;
          cnt       <= '0;
        end else begin
          cnt      <= cnt + 1'b1;
          out_last <= cnt == CW'(ML - 2);
        end
      end
    end
endmodule

// File: doc/opacc_stream.md
Name: opacc_stream

Overview:
- Parametrised successor to the outer-product accumulator: an ML x VL tile of ACCLEN-bit accumulators.
- Input elements are XLEN wide, with a configurable signed/unsigned multiply.
- A valid/ready command port handles LOAD, MAC and CLEAR; a valid/ready drain port streams C rows out in FIFO order.
- Sits between the vector register file and the MPU result path.

Parameters:
- XLEN, 8, width of A/B elements.
- ACCLEN, 32, accumulator element width; must be >= 2*XLEN.
- VL, 4, columns (B length, C row length).
- ML, 4, rows (A length, C row count).
- SIGNED, 1, 1 = two's-complement multiply, 0 = unsigned.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid && in_ready.
- in_op  in  2  0=LOAD, 1=MAC, 2=CLEAR, 3=reserved (no-op).
- vi_a  in  ML*XLEN  A vector, MAC only.
- vi_b  in  VL*XLEN  B vector, MAC only.
- vi_c  in  VL*ACCLEN  C row, LOAD only.
- drain_req  in  1  start draining the tile.
- out_valid  out  1  vo_c holds a valid row.
- out_ready  in  1  consumer accepts the row.
- vo_c  out  VL*ACCLEN  drained C row.
- out_last  out  1  final row of a drain.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state, including mid-drain):
  - state=IDLE; all reg_c=0; row counter=0.
  - out_valid=0, out_last=0, busy=0, vo_c=0.
  - in_ready=1 once reset deasserts.
- FSM states: IDLE and DRAIN.
  - IDLE -> DRAIN on drain_req.
  - DRAIN -> IDLE on the handshake of the row with out_last=1.
- in_ready = (state==IDLE) && !drain_req. drain_req has priority over a simultaneous command; that command stays pending.
- LOAD (handshake cycle, result visible next edge):
  - reg_c[0] <= vi_c.
  - reg_c[i] <= reg_c[i-1] for i = 1..ML-1.
  - reg_c[ML-1] is discarded.
  - After ML loads, the first row loaded sits in reg_c[ML-1].
- MAC (1-cycle latency):
  - reg_c[i][j] <= reg_c[i][j] + ext(a[i]) * ext(b[j]).
  - ext is sign extension when SIGNED=1, zero extension otherwise, of the full 2*XLEN product to ACCLEN.
  - Sum wraps modulo 2^ACCLEN.
  - Back-to-back MACs every cycle are supported.
- CLEAR: all reg_c <= 0 in one cycle.
- Reserved op: accepted; no state change.
- DRAIN:
  - out_valid=1; vo_c = reg_c[ML-1]; out_last = (row counter == ML-1).
  - On out_valid && out_ready: rows shift down, zeros enter reg_c[0], counter increments.
  - vo_c and out_last hold stable while out_valid && !out_ready.
  - Rows leave in load order; the tile is all-zero after the drain.
  - drain_req is ignored while in DRAIN.
- busy=1 only in DRAIN.
- A command accepted the cycle before drain_req is fully applied before the first row is presented (no hazard).

Optional Feature:
- Macro OPACC_SAT_EN.
  - Defined: MAC accumulation saturates. Signed clamps to [-2^(ACCLEN-1), 2^(ACCLEN-1)-1]; unsigned clamps to 2^ACCLEN-1.
  - Undefined: accumulation wraps modulo 2^ACCLEN.
- LOAD, CLEAR and DRAIN are unaffected either way.

Decomposition:
- Package opacc_pkg holds:
  - op enum: OP_LOAD, OP_MAC, OP_CLEAR, OP_RSVD;
  - state enum: ST_IDLE, ST_DRAIN;
  - a function computing the saturating/wrapping add, parameterised by ACCLEN and SIGNED.
- One natural sub-module: opacc_mac_row.
  - Contains one row of VL multiply-accumulate cells, given a[i] and b[].
  - Instantiated ML times.
  - Row shifting and the FSM stay in the top.

Test Plan (XLEN=8, ACCLEN=32, VL=ML=4, SIGNED=1):
1. Reset: hold reset 2 cycles -> all reg_c=0, out_valid=0, busy=0; in_ready=1 after release. Assert reset during the 2nd drain row -> immediate IDLE, out_valid=0, tile zero.
2. Load/drain order: LOAD rows r_i[j]=i*j for i=0..3, then pulse drain_req with out_ready=1 -> vo_c sequence r_0..r_3 on 4 consecutive cycles; out_last only with r_3; tile zero afterwards.
3. MAC: CLEAR, then MAC a={1,2,3,4}, b={5,6,7,8} twice back-to-back -> C[i][j]=2*a_i*b_j (C[0][0]=10, C[3][3]=64).
4. Signed extension: CLEAR, MAC a[0]=0x80 (-128), b[0]=0x7F (127) -> C[0][0]=0xFFFFC080. With SIGNED=0 -> 0x00003F80.
5. Backpressure/priority: drain_req and in_valid(MAC) in the same cycle -> in_ready=0, drain starts, MAC accepted after the drain ends. Hold out_ready=0 for 3 cycles mid-drain -> vo_c/out_last stable, no row lost.
6. Saturation: LOAD 0x7FFFFFF0 into C[0][0], MAC a[0]=b[0]=127 (+16129) -> with OPACC_SAT_EN, 0x7FFFFFFF; without it, 0x80003EF1.
